transmisor_dac_spi: RTL and testbench



---
 rtl/transmisor_dac_spi_pkg.sv | 16 +
 rtl/transmisor_dac_spi_conv.sv | 33 +++
 rtl/transmisor_dac_spi.sv | 177 +++++++++++++++++
 tb/tb_transmisor_dac_spi.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmisor_dac_spi_pkg.sv
// Shared constants and FSM state type for the DAC SPI transmitter.
package transmisor_dac_spi_pkg;

    localparam int unsigned FRAME_BITS   = 16;
    localparam logic [3:0]  CTRL_BITS    = 4'b0000;
    localparam logic [11:0] DAC_MIDSCALE = 12'h800;
    localparam logic [11:0] DAC_MAX      = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/transmisor_dac_spi_conv.sv
// Signed fixed-point sample to saturated offset-binary DAC code (combinational).
module sat_offset_dac
    import transmisor_dac_spi_pkg::*;
#(
    parameter int N     = 25,
    parameter int FRAC  = 16,
    parameter int DAC_W = 12
) (
    input  logic signed [N-1:0]     yk_i,
    output logic        [DAC_W-1:0] code_o
);

    localparam int SH = FRAC - (DAC_W - 1);

    logic signed [N-1:0] s;
    logic                in_range;

    assign s = yk_i >>> SH;

    // Fits in DAC_W signed bits exactly when every bit above the sign position agrees.
    assign in_range = (s[N-1:DAC_W-1] == '0) || (s[N-1:DAC_W-1] == '1);

    always_comb begin
        if (in_range) begin
            code_o = {~s[DAC_W-1], s[DAC_W-2:0]};
        end else if (s[N-1]) begin
            code_o = '0;
        end else begin
            code_o = DAC_MAX[DAC_W-1:0];
        end
    end

endmodule

// File: rtl/transmisor_dac_spi.sv
// SPI frame transmitter for a DAC121S101-style converter with a one-entry pending buffer.
module transmisor_dac_spi
    import transmisor_dac_spi_pkg::*;
#(
    parameter int N       = 25,
    parameter int FRAC    = 16,
    parameter int DAC_W   = 12,
    parameter int CLK_DIV = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic signed [N-1:0] Yk,
    input  logic                Bandera_Listo,
    output logic                SCLK,
    output logic                SYNC_n,
    output logic                SDATA,
    output logic                Ocupado,
    output logic                Sobrecarga,
    output logic                Trama_Lista,
    output logic [DAC_W-1:0]    Dato_DAC
);

    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    sclk_q, sclk_d;
    logic                    sync_n_q, sync_n_d;
    logic [DAC_W-1:0]        dato_q, dato_d;
    logic signed [N-1:0]     pend_q, pend_d;
    logic                    pend_v_q, pend_v_d;
    logic                    sobre_q, sobre_d;

    logic [DAC_W-1:0]        code_new, code_pend, load_code;
    logic                    load, gap_end;

    sat_offset_dac #(.N(N), .FRAC(FRAC), .DAC_W(DAC_W)) u_conv_new (
        .yk_i   (Yk),
        .code_o (code_new)
    );

    sat_offset_dac #(.N(N), .FRAC(FRAC), .DAC_W(DAC_W)) u_conv_pend (
        .yk_i   (pend_q),
        .code_o (code_pend)
    );

    assign gap_end = (state_q == ST_GAP) && (div_q == GAP_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            dato_q   <= DAC_MIDSCALE;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            sobre_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            dato_q   <= dato_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            sobre_q  <= sobre_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        dato_d    = dato_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        sobre_d   = 1'b0;
        load      = 1'b0;
        load_code = code_new;

        case (state_q)
            ST_IDLE: begin
                if (Bandera_Listo) begin
                    load = 1'b1;
                end
            end
            ST_HIGH: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_LOW;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    // Shifting on the final bit too leaves the register empty, so SDATA idles at 0.
                    shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_q == '0) begin
                        sync_n_d = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = ST_HIGH;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d = '0;
                    if (pend_v_q) begin
                        load      = 1'b1;
                        load_code = code_pend;
                        pend_v_d  = Bandera_Listo;
                        if (Bandera_Listo) begin
                            pend_d = Yk;
                        end
                    end else if (Bandera_Listo) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The gap-end edge frees the pending slot itself, so it is handled above without overflow.
        if (Bandera_Listo && (state_q != ST_IDLE) && !gap_end) begin
            pend_d   = Yk;
            pend_v_d = 1'b1;
            sobre_d  = pend_v_q;
        end

        if (load) begin
            state_d  = ST_HIGH;
            div_d    = '0;
            bit_d    = LAST_BIT;
            shreg_d  = {CTRL_BITS, load_code};
            dato_d   = load_code;
            sync_n_d = 1'b0;
            sclk_d   = 1'b1;
        end
    end

    assign SCLK        = sclk_q;
    assign SYNC_n      = sync_n_q;
    assign SDATA       = shreg_q[FRAME_BITS-1];
    assign Ocupado     = (state_q != ST_IDLE);
    assign Sobrecarga  = sobre_q;
    assign Trama_Lista = gap_end;
    assign Dato_DAC    = dato_q;

endmodule

// File: tb/tb_transmisor_dac_spi.sv
// Self-checking bench: table vectors, directed multi-frame sequences and a random run vs a frame-level model.
module tb_transmisor_dac_spi;

    localparam int N         = 25;
    localparam int FRAC      = 16;
    localparam int DAC_W     = 12;
    localparam int CLK_DIV   = 4;
    localparam int FRAME_CYC = 32 * CLK_DIV;
    localparam int PERIOD    = 34 * CLK_DIV;
    localparam int SCALE     = 1 << (FRAC - DAC_W + 1);

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [N-1:0]     Yk = '0;
    logic             Bandera_Listo = 1'b0;
    logic             SCLK, SYNC_n, SDATA, Ocupado, Sobrecarga, Trama_Lista;
    logic [DAC_W-1:0] Dato_DAC;

    transmisor_dac_spi #(.N(N), .FRAC(FRAC), .DAC_W(DAC_W), .CLK_DIV(CLK_DIV)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Yk            (Yk),
        .Bandera_Listo (Bandera_Listo),
        .SCLK          (SCLK),
        .SYNC_n        (SYNC_n),
        .SDATA         (SDATA),
        .Ocupado       (Ocupado),
        .Sobrecarga    (Sobrecarga),
        .Trama_Lista   (Trama_Lista),
        .Dato_DAC      (Dato_DAC)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [N-1:0]  yk;
        logic [11:0]   code;
    } vec_t;

    vec_t tbl[11];

    int errors = 0;
    int checks = 0;

    // frame-level model state
    int          k;
    int          busy_end;
    logic        pv;
    logic [11:0] pend_code;
    logic        sobre_flag;
    logic [11:0] dato_m;
    logic [11:0] exp_q[$];

    // serial monitor state
    logic        prev_sclk, prev_sync;
    logic [15:0] mon_bits;
    int          mon_cnt;
    int          frames_done = 0;

    int mm_ocup, mm_trama, mm_sobre, mm_sync, mm_sclk, mm_dato, mm_sdata;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, req, req, k);
        end
    endtask

    function automatic logic [11:0] conv(input logic [N-1:0] y);
        int v, s;
        v = y[N-1] ? (int'(y) - (1 << N)) : int'(y);
        if (v >= 0) s = v / SCALE;
        else        s = -((-v + SCALE - 1) / SCALE);
        if (s > 2047)  return 12'hFFF;
        if (s < -2048) return 12'h000;
        return 12'(s + 2048);
    endfunction

    function automatic logic [N-1:0] rnd_y();
        int mode, v;
        mode = int'($urandom_range(0, 3));
        case (mode)
            0: return N'($urandom);
            1: begin
                v = int'($urandom_range(0, 131071)) - 65536;
                return N'(v);
            end
            2: begin
                case ($urandom_range(0, 5))
                    0: return 25'h000FFE0;
                    1: return 25'h000FFFF;
                    2: return 25'h0010000;
                    3: return 25'h1FF0000;
                    4: return 25'h1FEFFFF;
                    default: return 25'h1FF001F;
                endcase
            end
            default: return N'($urandom_range(0, 255)) - N'(128);
        endcase
    endfunction

    task automatic model_reset();
        busy_end   = -1000;
        pv         = 1'b0;
        pend_code  = '0;
        sobre_flag = 1'b0;
        dato_m     = 12'h800;
        exp_q.delete();
        mon_cnt    = 0;
        mon_bits   = '0;
        prev_sync  = 1'b1;
        prev_sclk  = 1'b1;
    endtask

    task automatic start_frame(input logic [11:0] c);
        busy_end = k + PERIOD;
        dato_m   = c;
        exp_q.push_back(c);
    endtask

    task automatic frame_end();
        logic [11:0] c;
        frames_done++;
        check_eq("frame_edges", mon_cnt, 16);
        check_eq("frame_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            check_eq("frame_bits", int'(mon_bits), int'({4'b0000, c}));
        end
    endtask

    task automatic sample();
        int   st;
        logic e_sync_low, e_sclk, e_ocup, e_trama;
        st         = busy_end - PERIOD;
        e_sync_low = (k > st) && (k <= st + FRAME_CYC);
        e_sclk     = e_sync_low ? (((k - st - 1) % (2 * CLK_DIV)) < CLK_DIV) : 1'b1;
        e_ocup     = (k <= busy_end);
        e_trama    = (k == busy_end);
        if (Ocupado !== e_ocup)         mm_ocup++;
        if (Trama_Lista !== e_trama)    mm_trama++;
        if (Sobrecarga !== sobre_flag)  mm_sobre++;
        if (SYNC_n !== !e_sync_low)     mm_sync++;
        if (SCLK !== e_sclk)            mm_sclk++;
        if (Dato_DAC !== dato_m)        mm_dato++;
        if (!e_sync_low && SDATA !== 1'b0) mm_sdata++;

        if (prev_sync && !SYNC_n) begin
            mon_cnt  = 0;
            mon_bits = '0;
        end
        if (prev_sclk && !SCLK && !SYNC_n) begin
            mon_bits = {mon_bits[14:0], SDATA};
            mon_cnt++;
        end
        if (!prev_sync && SYNC_n && !Reset) frame_end();
        prev_sclk = SCLK;
        prev_sync = SYNC_n;
    endtask

    task automatic model_update(input logic s, input logic [N-1:0] y);
        logic [11:0] c;
        logic        sobre_next;
        c          = conv(y);
        sobre_next = 1'b0;
        if (k == busy_end) begin
            if (pv) begin
                start_frame(pend_code);
                if (s) pend_code = c;
                else   pv = 1'b0;
            end else if (s) begin
                start_frame(c);
            end
        end else if (s) begin
            if (k > busy_end) begin
                start_frame(c);
            end else begin
                sobre_next = pv;
                pend_code  = c;
                pv         = 1'b1;
            end
        end
        sobre_flag = sobre_next;
    endtask

    task automatic step(input logic s, input logic [N-1:0] y);
        @(posedge Clk);
        #1;
        Bandera_Listo = s;
        Yk            = y;
        @(negedge Clk);
        sample();
        model_update(s, y);
        k++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, rnd_y());
    endtask

    task automatic check_traces(input string ph);
        check_eq({ph, "_ocupado_trace"}, mm_ocup, 0);
        check_eq({ph, "_trama_trace"},   mm_trama, 0);
        check_eq({ph, "_sobre_trace"},   mm_sobre, 0);
        check_eq({ph, "_sync_trace"},    mm_sync, 0);
        check_eq({ph, "_sclk_trace"},    mm_sclk, 0);
        check_eq({ph, "_dato_trace"},    mm_dato, 0);
        check_eq({ph, "_sdata_idle"},    mm_sdata, 0);
        check_eq({ph, "_frames_left"},   exp_q.size(), 0);
        mm_ocup = 0; mm_trama = 0; mm_sobre = 0; mm_sync = 0;
        mm_sclk = 0; mm_dato = 0; mm_sdata = 0;
    endtask

    initial begin
        int   k0, cnt_a, cnt_b, first, fr0;
        logic ps;

        tbl[0]  = '{25'h0000000, 12'h800};
        tbl[1]  = '{25'h0008000, 12'hC00};
        tbl[2]  = '{25'h000F000, 12'hF80};
        tbl[3]  = '{25'h0010000, 12'hFFF};
        tbl[4]  = '{25'h1FF0000, 12'h000};
        tbl[5]  = '{25'h1F00000, 12'h000};
        tbl[6]  = '{25'h000FFE0, 12'hFFF};
        tbl[7]  = '{25'h000FFDF, 12'hFFE};
        tbl[8]  = '{25'h1FFFFFF, 12'h7FF};
        tbl[9]  = '{25'h0000020, 12'h801};
        tbl[10] = '{25'h1FF0020, 12'h001};

        mm_ocup = 0; mm_trama = 0; mm_sobre = 0; mm_sync = 0;
        mm_sclk = 0; mm_dato = 0; mm_sdata = 0;
        k = 0;
        model_reset();

        #1 Reset = 1'b1;
        @(negedge Clk);
        check_eq("rst_sclk",   int'(SCLK), 1);
        check_eq("rst_sync_n", int'(SYNC_n), 1);
        check_eq("rst_sdata",  int'(SDATA), 0);
        check_eq("rst_ocupado", int'(Ocupado), 0);
        check_eq("rst_sobrecarga", int'(Sobrecarga), 0);
        check_eq("rst_trama", int'(Trama_Lista), 0);
        check_eq("rst_dato",  int'(Dato_DAC), 'h800);
        repeat (3) step(1'b0, '0);
        Reset = 1'b0;
        idle(3);

        // single frame at midscale: exact timing
        k0 = k;
        step(1'b1, '0);
        cnt_a = 0; cnt_b = 0; first = -1;
        for (int i = 1; i <= 150; i++) begin
            step(1'b0, rnd_y());
            if (i == 1) check_eq("mid_dato", int'(Dato_DAC), 'h800);
            if (!SYNC_n) cnt_a++;
            if (Trama_Lista) begin
                cnt_b++;
                if (first < 0) first = i;
            end
        end
        check_eq("mid_sync_low_cycles", cnt_a, FRAME_CYC);
        check_eq("mid_trama_offset", first, PERIOD);
        check_eq("mid_trama_pulses", cnt_b, 1);

        for (int v = 0; v < 11; v++) begin
            step(1'b1, tbl[v].yk);
            step(1'b0, rnd_y());
            check_eq($sformatf("tbl%0d_dato", v), int'(Dato_DAC), int'(tbl[v].code));
            idle(140);
        end
        check_traces("table");

        // back-to-back: A at 0, B at 50
        k0 = k; ps = SYNC_n; cnt_a = 0; cnt_b = 0; first = -1;
        step(1'b1, 25'h1FF8000);
        for (int i = 1; i <= 320; i++) begin
            step(i == 50, (i == 50) ? 25'h0004000 : rnd_y());
            if (ps && !SYNC_n) begin
                cnt_a++;
                if (cnt_a == 2) first = i;
            end
            ps = SYNC_n;
            if (i <= 2 * PERIOD && !Ocupado) cnt_b++;
            if (Sobrecarga) cnt_b += 1000;
        end
        check_eq("b2b_second_sync_fall", first, PERIOD + 1);
        check_eq("b2b_ocupado_drop_or_sobre", cnt_b, 0);
        check_traces("b2b");

        // overwrite: A at 0, B at 40, C at 80
        k0 = k; fr0 = frames_done; cnt_a = 0; first = -1;
        step(1'b1, 25'h1FF8000);
        for (int i = 1; i <= 400; i++) begin
            if (i == 40)      step(1'b1, 25'h000F000);
            else if (i == 80) step(1'b1, 25'h0008000);
            else              step(1'b0, rnd_y());
            if (Sobrecarga) begin
                cnt_a++;
                if (first < 0) first = i;
            end
            if (i == PERIOD + 1) check_eq("ovw_second_dato", int'(Dato_DAC), 'hC00);
        end
        check_eq("ovw_sobre_cycle", first, 81);
        check_eq("ovw_sobre_pulses", cnt_a, 1);
        check_eq("ovw_frames_sent", frames_done - fr0, 2);
        check_traces("ovw");

        // asynchronous reset in the middle of a frame, SCLK low at that moment
        step(1'b1, 25'h0004000);
        for (int i = 1; i <= 62; i++) step(1'b0, rnd_y());
        check_eq("mrst_pre_sclk", int'(SCLK), 0);
        #2 Reset = 1'b1;
        #1;
        check_eq("mrst_sync_n", int'(SYNC_n), 1);
        check_eq("mrst_sclk", int'(SCLK), 1);
        check_eq("mrst_ocupado", int'(Ocupado), 0);
        check_eq("mrst_dato", int'(Dato_DAC), 'h800);
        model_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        Reset = 1'b0;
        fr0 = frames_done;
        step(1'b1, 25'h1FFC000);
        idle(150);
        check_eq("mrst_frames_after", frames_done - fr0, 1);
        check_traces("mrst");

        // strobe on the Trama_Lista cycle with pending empty
        k0 = k; ps = SYNC_n; cnt_a = 0; cnt_b = 0; first = -1;
        step(1'b1, 25'h000F000);
        for (int i = 1; i <= 300; i++) begin
            step(i == PERIOD, (i == PERIOD) ? 25'h1FF0000 : rnd_y());
            if (i == PERIOD) check_eq("tl_trama_now", int'(Trama_Lista), 1);
            if (ps && !SYNC_n) begin
                cnt_a++;
                if (cnt_a == 2) first = i;
            end
            ps = SYNC_n;
            if (i <= 2 * PERIOD && !Ocupado) cnt_b++;
        end
        check_eq("tl_second_sync_fall", first, PERIOD + 1);
        check_eq("tl_ocupado_drops", cnt_b, 0);
        check_traces("tl");

        // strobe on the Trama_Lista cycle with pending valid
        fr0 = frames_done; cnt_a = 0;
        step(1'b1, 25'h0000020);
        for (int i = 1; i <= 600; i++) begin
            step(i == 10 || i == PERIOD, (i == 10) ? 25'h1FFFFFF : (i == PERIOD) ? 25'h0010000 : rnd_y());
            if (Sobrecarga) cnt_a++;
        end
        check_eq("tlp_sobre_pulses", cnt_a, 0);
        check_eq("tlp_frames_sent", frames_done - fr0, 3);
        check_traces("tlp");

        // random strobes and samples against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 59) == 0, rnd_y());
        end
        idle(300);
        check_traces("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
